mux_rr_arbiter: RTL and testbench
=================================

Name: mux_rr_arbiter

Overview:
- Two-requester round-robin arbiter that shares one 2:1 data mux path between source 0 and source 1.
- Each source has a valid/ready handshake. The winning source's data is steered through the mux into a single registered output slot with its own valid/ready handshake.
- A granted source keeps ownership for a burst of up to BURST_LEN transfers, then ownership rotates.
- Sits between two producers and one shared downstream consumer.

Parameters:
- DATA_WIDTH, 8, width of din_0, din_1, mux_out.
- BURST_LEN, 4, maximum consecutive transfers per grant; legal range 1..255.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- din_0  input  DATA_WIDTH  source 0 data.
- valid_0  input  1  source 0 data valid.
- ready_0  output  1  source 0 accepted this cycle (transfer = valid_0 & ready_0).
- din_1  input  DATA_WIDTH  source 1 data.
- valid_1  input  1  source 1 data valid.
- ready_1  output  1  source 1 accepted this cycle.
- mux_out  output  DATA_WIDTH  registered output data.
- out_valid  output  1  mux_out holds valid data.
- out_ready  input  1  downstream accepts mux_out (transfer = out_valid & out_ready).
- sel  output  1  registered; which source produced the current mux_out.

Behaviour:
- Reset (rst=1 at a clk edge):
  - state=IDLE, last_grant=1 (first tie goes to source 0), beat_cnt=0.
  - out_valid=0, mux_out=0, sel=0; ready_0=ready_1=0 while in IDLE.
  - Reset mid-burst discards the output slot contents; no transfer completes in the reset cycle.
- States: IDLE, OWN0, OWN1.
- IDLE:
  - ready_0=ready_1=0.
  - If valid_0 & valid_1: next state is OWN(~last_grant).
  - Else if only valid_x: next state is OWNx.
  - Else stay in IDLE.
  - beat_cnt cleared on entry to OWNx.
  - Arbitration latency is 1 cycle: a request seen in IDLE at cycle n can first be accepted at cycle n+1.
- OWNx:
  - ready_x = ~out_valid | out_ready; ready of the other source = 0.
  - ready_x does not depend on valid_x; no combinational valid-to-ready path.
  - On valid_x & ready_x: mux_out<=din_x, out_valid<=1, sel<=x, beat_cnt<=beat_cnt+1.
  - Leave to IDLE with last_grant<=x when either:
    - a transfer makes beat_cnt reach BURST_LEN, or
    - valid_x=0 in a cycle with no transfer.
  - Otherwise stay in OWNx.
  - After a full burst the source must go back through IDLE: one bubble cycle between bursts.
- Output slot:
  - If out_valid & out_ready and no new load that cycle: out_valid<=0; mux_out and sel hold their last values.
  - Simultaneous drain and load: the new data replaces the old; out_valid stays 1.
  - With out_ready=0 and out_valid=1, mux_out and sel are stable and ready_x=0.
  - Throughput is 1 transfer per cycle when out_ready=1.
- Data integrity: no beat is dropped or duplicated, and beats from one source leave in acceptance order.
- beat_cnt width is 8 bits; it never wraps because it is cleared on every entry to OWNx.

Test Plan (DATA_WIDTH=8, BURST_LEN=4):
- Reset: hold rst=1 for 2 cycles with valid_0=valid_1=1 -> out_valid=0, mux_out=0x00, sel=0, ready_0=ready_1=0; state IDLE after release.
- Single source: valid_0=1, din_0=0xA5, out_ready=1 starting cycle 0 -> ready_0=1 at cycle 1; out_valid=1, mux_out=0xA5, sel=0 at cycle 2; ready_1 stays 0 throughout.
- Contention: both valid continuously, din_0=0x10..0x17, din_1=0x20..0x27, out_ready=1 -> output stream 0x10-0x13 (sel=0), one bubble, 0x20-0x23 (sel=1), one bubble, 0x14-0x17, one bubble, 0x24-0x27.
- Backpressure: during an OWN0 burst, drop out_ready=0 for 3 cycles with out_valid=1 -> ready_0=0 and mux_out constant; on release, beats resume in order with no loss or duplication.
- Early release: valid_0 deasserts after 2 accepted beats while valid_1=1 -> 1 cycle in IDLE, then OWN1; source 1 gets a full 4-beat burst (beat_cnt restarted).
- Reset mid-burst: assert rst after beat 2 of an OWN1 burst -> next cycle out_valid=0, ready_1=0; a subsequent tie grants source 0 first.

Source files
------------

// File: rtl/mux_rr_arbiter.sv
// mux_rr_arbiter: two-source round-robin burst arbiter feeding one registered output slot
module mux_rr_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int BURST_LEN  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] din_0,
  input  logic                  valid_0,
  output logic                  ready_0,
  input  logic [DATA_WIDTH-1:0] din_1,
  input  logic                  valid_1,
  output logic                  ready_1,
  output logic [DATA_WIDTH-1:0] mux_out,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  sel
);
  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;
  state_t                  state_q;
  logic                    last_grant_q;
  logic [7:0]              beat_cnt_q;
  logic [DATA_WIDTH-1:0]   mux_out_q;
  logic                    out_valid_q;
  logic                    sel_q;
  logic                    own;
  logic                    src;
  logic                    rdy;
  logic                    vld;
  logic                    xfer;
  logic                    last_beat;
  logic [DATA_WIDTH-1:0]   din;
  assign own       = state_q != IDLE;
  assign src       = state_q == OWN1;
  // ready is masked during reset so no beat is accepted in the reset cycle
  assign rdy       = own & ~rst & (~out_valid_q | out_ready);
  assign vld       = src ? valid_1 : valid_0;
  assign din       = src ? din_1 : din_0;
  assign xfer      = rdy & vld;
  assign last_beat = (beat_cnt_q + 8'd1) == 8'(BURST_LEN);
  assign ready_0   = rdy & ~src;
  assign ready_1   = rdy & src;
  assign mux_out   = mux_out_q;
  assign out_valid = out_valid_q;
  assign sel       = sel_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      beat_cnt_q   <= '0;
      out_valid_q  <= 1'b0;
      mux_out_q    <= '0;
      sel_q        <= 1'b0;
    end else begin
      if (!own) begin
        state_q    <= (valid_0 & valid_1) ? (last_grant_q ? OWN0 : OWN1) :
                      valid_0 ? OWN0 : valid_1 ? OWN1 : IDLE;
        beat_cnt_q <= '0;
      end else if (xfer ? last_beat : ~vld) begin
        state_q      <= IDLE;
        last_grant_q <= src;
      end
      if (xfer) begin
        mux_out_q   <= din;
        sel_q       <= src;
        out_valid_q <= 1'b1;
        beat_cnt_q  <= beat_cnt_q + 8'd1;
      end else if (out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_mux_rr_arbiter.sv
// tb_mux_rr_arbiter: directed-vector bench for the round-robin burst arbiter
module tb_mux_rr_arbiter;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] din_0 = '0;
  logic [7:0] din_1 = '0;
  logic       valid_0 = 1'b0;
  logic       valid_1 = 1'b0;
  logic       out_ready = 1'b0;
  logic       ready_0;
  logic       ready_1;
  logic [7:0] mux_out;
  logic       out_valid;
  logic       sel;
  int         checks = 0;
  int         errs = 0;
  int         i0;
  int         i1;
  logic [8:0] rx[$];
  logic [9:0] r1_mask;
  // {out_valid, sel, mux_out} expected on cycles 1..20 of the contention run
  logic [9:0] cont_exp [20] = '{10'h000, 10'h210, 10'h211, 10'h212, 10'h213, 10'h013,
                                10'h320, 10'h321, 10'h322, 10'h323, 10'h123,
                                10'h214, 10'h215, 10'h216, 10'h217, 10'h017,
                                10'h324, 10'h325, 10'h326, 10'h327};
  logic [8:0] er_exp [6] = '{9'h040, 9'h041, 9'h150, 9'h151, 9'h152, 9'h153};

  mux_rr_arbiter #(.DATA_WIDTH(8), .BURST_LEN(4)) dut (
    .clk(clk), .rst(rst),
    .din_0(din_0), .valid_0(valid_0), .ready_0(ready_0),
    .din_1(din_1), .valid_1(valid_1), .ready_1(ready_1),
    .mux_out(mux_out), .out_valid(out_valid), .out_ready(out_ready), .sel(sel)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    valid_0 = 1'b0;
    valid_1 = 1'b0;
    out_ready = 1'b0;
    tick;
    tick;
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    valid_0 = 1'b1;
    valid_1 = 1'b1;
    tick;
    tick;
    chk("rst_ovalid", 32'(out_valid), 32'd0);
    chk("rst_mux", 32'(mux_out), 32'h00);
    chk("rst_sel", 32'(sel), 32'd0);
    chk("rst_rdy0", 32'(ready_0), 32'd0);
    chk("rst_rdy1", 32'(ready_1), 32'd0);
    rst = 1'b0;
    valid_0 = 1'b0;
    valid_1 = 1'b0;
    tick;
    chk("idle_rdy", 32'({ready_0, ready_1}), 32'd0);

    do_reset;
    valid_0 = 1'b1;
    din_0 = 8'hA5;
    out_ready = 1'b1;
    #1;
    chk("single_c0_rdy0", 32'(ready_0), 32'd0);
    tick;
    chk("single_c1_rdy0", 32'(ready_0), 32'd1);
    chk("single_c1_rdy1", 32'(ready_1), 32'd0);
    tick;
    chk("single_c2_out", 32'({out_valid, sel, mux_out}), 32'h2A5);
    chk("single_c2_rdy1", 32'(ready_1), 32'd0);
    valid_0 = 1'b0;
    tick;

    do_reset;
    i0 = 0;
    i1 = 0;
    for (int c = 0; c <= 20; c++) begin
      if (c > 0) chk("cont", 32'({out_valid, sel, mux_out}), 32'(cont_exp[c-1]));
      valid_0 = i0 < 8;
      valid_1 = i1 < 8;
      din_0 = 8'(8'h10 + i0);
      din_1 = 8'(8'h20 + i1);
      out_ready = 1'b1;
      #1;
      if (valid_0 && ready_0) i0++;
      if (valid_1 && ready_1) i1++;
      tick;
    end
    chk("cont_n0", 32'(i0), 32'd8);
    chk("cont_n1", 32'(i1), 32'd8);

    do_reset;
    i0 = 0;
    rx.delete();
    for (int c = 0; c < 16; c++) begin
      valid_0 = i0 < 8;
      din_0 = 8'(8'h30 + i0);
      out_ready = !(c >= 2 && c <= 4);
      #1;
      if (c >= 2 && c <= 4) begin
        chk("bp_rdy0", 32'(ready_0), 32'd0);
        chk("bp_hold", 32'({out_valid, sel, mux_out}), 32'h230);
      end
      if (out_valid && out_ready) rx.push_back({sel, mux_out});
      if (valid_0 && ready_0) i0++;
      tick;
    end
    chk("bp_cnt", 32'(rx.size()), 32'd8);
    for (int k = 0; k < rx.size() && k < 8; k++) chk("bp_beat", 32'(rx[k]), 32'(8'h30 + k));

    do_reset;
    i0 = 0;
    i1 = 0;
    rx.delete();
    r1_mask = '0;
    for (int c = 0; c < 11; c++) begin
      valid_0 = i0 < 2;
      valid_1 = i1 < 8;
      din_0 = 8'(8'h40 + i0);
      din_1 = 8'(8'h50 + i1);
      out_ready = 1'b1;
      #1;
      if (c < 10) r1_mask[c] = ready_1;
      if (out_valid && out_ready) rx.push_back({sel, mux_out});
      if (valid_0 && ready_0) i0++;
      if (valid_1 && ready_1) i1++;
      tick;
    end
    chk("er_rdy1_mask", 32'(r1_mask), 32'h1E0);
    chk("er_cnt", 32'(rx.size()), 32'd6);
    for (int k = 0; k < rx.size() && k < 6; k++) chk("er_beat", 32'(rx[k]), 32'(er_exp[k]));

    do_reset;
    i1 = 0;
    for (int c = 0; c < 3; c++) begin
      valid_1 = 1'b1;
      din_1 = 8'(8'h60 + i1);
      out_ready = 1'b1;
      #1;
      if (valid_1 && ready_1) i1++;
      tick;
    end
    chk("mr_beats", 32'(i1), 32'd2);
    rst = 1'b1;
    valid_0 = 1'b1;
    #1;
    chk("mr_rst_rdy1", 32'(ready_1), 32'd0);
    tick;
    rst = 1'b0;
    #1;
    chk("mr_ovalid", 32'(out_valid), 32'd0);
    chk("mr_rdy1", 32'(ready_1), 32'd0);
    tick;
    chk("mr_tie_rdy0", 32'(ready_0), 32'd1);
    chk("mr_tie_rdy1", 32'(ready_1), 32'd0);
    valid_0 = 1'b0;
    valid_1 = 1'b0;
    tick;

    $display("CHECKS %0d ERRORS %0d", checks, errs);
    $finish;
  end
endmodule
